mem_access_unit: RTL and testbench

Memory-stage access controller for the 16-bit pipelined core. It sits between the EX/MEM pipeline register and the MEM/WB register, and it runs each load or store as a multi-cycle request/response transaction to data memory. While a transaction is in flight it stalls the front of the pipeline and presents the load result as `dmem_out` for MEM/WB to capture. It also forwards the writeback value into store data (MEM-to-MEM forwarding) and flags unresponsive memory with a timeout.

---
 rtl/mem_access_unit.sv | 134 +++++++++++++
 tb/tb_mem_access_unit.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Memory-stage access controller: runs each load/store as a request/response
// transaction to data memory, stalling the pipeline front until it completes.
module mem_access_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [15:0] addr,
    input  logic [15:0] store_data,
    input  logic [3:0]  store_rt,
    input  logic        wb_RegWrite,
    input  logic [3:0]  wb_rd,
    input  logic [15:0] wb_data,
    input  logic        mem_valid,
    input  logic [15:0] mem_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic [15:0] dmem_out,
    output logic        mem_stall,
    output logic        mem_err
);

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StBusy,
        StDone
    } state_e;

    localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  cnt_inc;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] dmem_q, dmem_d;
    logic        we_q, we_d;
    logic        err_q, err_d;
    logic        access;
    logic        fwd_hit;

    assign access  = ex_valid & (MemRead | MemWrite);
    // MEM-to-MEM forwarding: r0 is never a real producer.
    assign fwd_hit = wb_RegWrite & (wb_rd == store_rt) & (wb_rd != 4'd0);
    assign cnt_inc = cnt_q + 8'd1;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        dmem_d    = dmem_q;
        we_d      = we_q;
        err_d     = err_q;
        mem_req   = 1'b0;
        mem_stall = 1'b0;

        case (state_q)
            StIdle: begin
                mem_stall = access;
                if (access) begin
                    addr_d  = {addr[15:1], 1'b0};
                    we_d    = MemWrite;
                    wdata_d = fwd_hit ? wb_data : store_data;
                    state_d = StReq;
                end
            end
            StReq: begin
                mem_req   = 1'b1;
                mem_stall = 1'b1;
                cnt_d     = 8'd0;
                state_d   = StBusy;
            end
            StBusy: begin
                mem_stall = 1'b1;
                // A response in the final counted cycle beats the timeout.
                if (mem_valid) begin
                    if (!we_q) begin
                        dmem_d = mem_rdata;
                    end
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == TimeoutCnt) begin
                        err_d = 1'b1;
                        if (!we_q) begin
                            dmem_d = 16'h0000;
                        end
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 8'd0;
            addr_q  <= 16'h0000;
            wdata_q <= 16'h0000;
            dmem_q  <= 16'h0000;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            dmem_q  <= dmem_d;
            we_q    <= we_d;
            err_q   <= err_d;
        end
    end

    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign dmem_out  = dmem_q;
    assign mem_err   = err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed vector table, reset corner case, then
// random instructions checked against a transaction-level model.
module tb_mem_access_unit;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, MemRead, MemWrite, wb_RegWrite, mem_valid;
    logic [15:0] addr, store_data, wb_data, mem_rdata;
    logic [3:0]  store_rt, wb_rd;
    logic        mem_req, mem_we, mem_stall, mem_err;
    logic [15:0] mem_addr, mem_wdata, dmem_out;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .ex_valid   (ex_valid),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .addr       (addr),
        .store_data (store_data),
        .store_rt   (store_rt),
        .wb_RegWrite(wb_RegWrite),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .mem_valid  (mem_valid),
        .mem_rdata  (mem_rdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .dmem_out   (dmem_out),
        .mem_stall  (mem_stall),
        .mem_err    (mem_err)
    );

    // lat: cycles from mem_req to mem_valid; 0 = memory never answers.
    typedef struct {
        logic        ev, rd, wr;
        logic [15:0] addr, sdata;
        logic [3:0]  srt;
        logic        wbre;
        logic [3:0]  wbrd;
        logic [15:0] wbdata;
        int          lat;
        logic [15:0] rdata;
        int          exp_stalls;
        logic [15:0] exp_addr;
        logic        exp_we;
        logic [15:0] exp_wdata, exp_dmem;
        logic        exp_err;
    } vec_t;

    vec_t tbl[$];

    // Reference model state (what the unit should be holding)
    logic [15:0] m_addr, m_wdata, m_dmem;
    logic        m_we, m_err;

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %0h required %0h", name, idx, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic ev, rd, wr, input logic [15:0] a, sd, input logic [3:0] srt,
        input logic wbre, input logic [3:0] wbrd, input logic [15:0] wbd, input int lat,
        input logic [15:0] rdat, input int es, input logic [15:0] ea, input logic ewe,
        input logic [15:0] ewd, ed, input logic ee);
        vec_t v;
        v.ev = ev; v.rd = rd; v.wr = wr; v.addr = a; v.sdata = sd; v.srt = srt;
        v.wbre = wbre; v.wbrd = wbrd; v.wbdata = wbd; v.lat = lat; v.rdata = rdat;
        v.exp_stalls = es; v.exp_addr = ea; v.exp_we = ewe; v.exp_wdata = ewd;
        v.exp_dmem = ed; v.exp_err = ee;
        return v;
    endfunction

    task automatic model(input vec_t vi, output vec_t vo);
        vo = vi;
        vo.exp_stalls = 0;
        if (vi.ev && (vi.rd || vi.wr)) begin
            m_addr  = vi.addr & 16'hFFFE;
            m_we    = vi.wr;
            m_wdata = (vi.wbre && vi.wbrd == vi.srt && vi.wbrd != 4'd0) ? vi.wbdata : vi.sdata;
            if (vi.lat >= 1 && vi.lat <= int'(TO)) begin
                vo.exp_stalls = vi.lat + 2;
                if (!vi.wr) m_dmem = vi.rdata;
            end else begin
                vo.exp_stalls = int'(TO) + 2;
                m_err = 1'b1;
                if (!vi.wr) m_dmem = 16'h0000;
            end
        end
        vo.exp_addr  = m_addr;
        vo.exp_we    = m_we;
        vo.exp_wdata = m_wdata;
        vo.exp_dmem  = m_dmem;
        vo.exp_err   = m_err;
    endtask

    task automatic drive_idle();
        ex_valid = 0; MemRead = 0; MemWrite = 0; addr = 0; store_data = 0; store_rt = 0;
        wb_RegWrite = 0; wb_rd = 0; wb_data = 0; mem_valid = 0; mem_rdata = 0;
    endtask

    task automatic check_reset_outputs(input int idx);
        check("rst_mem_req", idx, 32'(mem_req), 32'd0);
        check("rst_mem_we", idx, 32'(mem_we), 32'd0);
        check("rst_mem_stall", idx, 32'(mem_stall), 32'd0);
        check("rst_mem_err", idx, 32'(mem_err), 32'd0);
        check("rst_mem_addr", idx, 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", idx, 32'(mem_wdata), 32'd0);
        check("rst_dmem_out", idx, 32'(dmem_out), 32'd0);
    endtask

    // Entered #1 after a rising edge; returns #1 after the edge that ends the instruction.
    task automatic apply(input vec_t v, input int idx);
        int   stalls = 0;
        int   reqs   = 0;
        int   since  = 0;
        logic req_now;
        logic done   = 1'b0;
        ex_valid = v.ev; MemRead = v.rd; MemWrite = v.wr; addr = v.addr;
        store_data = v.sdata; store_rt = v.srt; wb_RegWrite = v.wbre; wb_rd = v.wbrd;
        wb_data = v.wbdata; mem_rdata = v.rdata;
        for (int cyc = 0; cyc < 64 && !done; cyc++) begin
            mem_valid = (v.lat > 0) && (since == v.lat);
            @(negedge clk);
            req_now = mem_req;
            if (mem_req) reqs++;
            if (mem_stall) begin
                stalls++;
            end else begin
                done = 1'b1;
                check("addr", idx, 32'(mem_addr), 32'(v.exp_addr));
                check("we", idx, 32'(mem_we), 32'(v.exp_we));
                check("wdata", idx, 32'(mem_wdata), 32'(v.exp_wdata));
                check("dmem_out", idx, 32'(dmem_out), 32'(v.exp_dmem));
                check("err", idx, 32'(mem_err), 32'(v.exp_err));
            end
            @(posedge clk);
            #1;
            if (req_now) since = 1;
            else if (since > 0) since++;
        end
        mem_valid = 1'b0;
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL stall_bound[%0d]: got stall beyond 64 cycles required %0d",
                     idx, v.exp_stalls);
        end
        check("stalls", idx, 32'(stalls), 32'(v.exp_stalls));
        check("reqs", idx, 32'(reqs), (v.ev && (v.rd || v.wr)) ? 32'd1 : 32'd0);
    endtask

    initial begin
        vec_t v, vm;
        drive_idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs(0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        //           ev rd wr addr      sdata     srt wbre wbrd wbdata   lat rdata     st addr      we wdata     dmem      err
        tbl.push_back(mk(1, 0, 0, 16'h1234, 16'h0000, 0, 0, 0, 16'h0000, 1, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0));
        tbl.push_back(mk(1, 1, 0, 16'h0011, 16'h0000, 0, 0, 0, 16'h0000, 2, 16'hBEEF, 4, 16'h0010, 0, 16'h0000, 16'hBEEF, 0));
        tbl.push_back(mk(1, 0, 1, 16'h0100, 16'h1111, 3, 1, 3, 16'h2222, 1, 16'h0000, 3, 16'h0100, 1, 16'h2222, 16'hBEEF, 0));
        tbl.push_back(mk(1, 0, 1, 16'h0201, 16'h1111, 0, 1, 0, 16'h2222, 3, 16'h0000, 5, 16'h0200, 1, 16'h1111, 16'hBEEF, 0));
        tbl.push_back(mk(1, 0, 1, 16'h0300, 16'h3333, 5, 0, 5, 16'h4444, 1, 16'h0000, 3, 16'h0300, 1, 16'h3333, 16'hBEEF, 0));
        tbl.push_back(mk(1, 1, 1, 16'h0402, 16'h5555, 2, 1, 3, 16'h6666, 1, 16'h9999, 3, 16'h0402, 1, 16'h5555, 16'hBEEF, 0));
        tbl.push_back(mk(0, 1, 0, 16'h0777, 16'h0000, 0, 0, 0, 16'h0000, 1, 16'h0000, 0, 16'h0402, 1, 16'h5555, 16'hBEEF, 0));
        tbl.push_back(mk(1, 1, 0, 16'h0500, 16'h0000, 0, 0, 0, 16'h0000, 4, 16'hCAFE, 6, 16'h0500, 0, 16'h0000, 16'hCAFE, 0));
        tbl.push_back(mk(1, 1, 0, 16'h0600, 16'h0000, 0, 0, 0, 16'h0000, 0, 16'h5A5A, 6, 16'h0600, 0, 16'h0000, 16'h0000, 1));
        tbl.push_back(mk(1, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 1, 16'h0000, 0, 16'h0600, 0, 16'h0000, 16'h0000, 1));
        tbl.push_back(mk(1, 1, 0, 16'h0700, 16'h0000, 0, 0, 0, 16'h0000, 1, 16'h1357, 3, 16'h0700, 0, 16'h0000, 16'h1357, 1));
        tbl.push_back(mk(1, 1, 0, 16'h0702, 16'h0000, 0, 0, 0, 16'h0000, 2, 16'h2468, 4, 16'h0702, 0, 16'h0000, 16'h2468, 1));
        tbl.push_back(mk(1, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 1, 16'h0000, 0, 16'h0702, 0, 16'h0000, 16'h2468, 1));
        tbl.push_back(mk(1, 1, 0, 16'h0800, 16'h0000, 0, 0, 0, 16'h0000, 1, 16'hAAAA, 3, 16'h0800, 0, 16'h0000, 16'hAAAA, 1));
        tbl.push_back(mk(1, 1, 0, 16'h0803, 16'h0000, 0, 0, 0, 16'h0000, 1, 16'hBBBB, 3, 16'h0802, 0, 16'h0000, 16'hBBBB, 1));
        tbl.push_back(mk(1, 0, 1, 16'h0900, 16'h7777, 1, 1, 2, 16'h8888, 0, 16'h0000, 6, 16'h0900, 1, 16'h7777, 16'hBBBB, 1));

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], i);
        end

        // Reset while BUSY, then a stray response that must be ignored.
        ex_valid = 1; MemRead = 1; MemWrite = 0; addr = 16'h0A01;
        @(posedge clk);
        @(posedge clk);
        #2;
        check("busy_stall", 100, 32'(mem_stall), 32'd1);
        check("busy_addr", 100, 32'(mem_addr), 32'h0A00);
        rst = 1'b1;
        #1;
        drive_idle();
        #1;
        check_reset_outputs(101);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        mem_valid = 1'b1;
        mem_rdata = 16'hFFFF;
        @(negedge clk);
        check("stray_req", 102, 32'(mem_req), 32'd0);
        check("stray_stall", 102, 32'(mem_stall), 32'd0);
        @(posedge clk);
        #1;
        mem_valid = 1'b0;
        @(negedge clk);
        check_reset_outputs(103);
        @(posedge clk);
        #1;

        m_addr = 0; m_wdata = 0; m_dmem = 0; m_we = 0; m_err = 0;
        for (int i = 0; i < 200; i++) begin
            v.ev     = ($urandom_range(0, 9) != 0);
            v.rd     = 1'($urandom_range(0, 1));
            v.wr     = 1'($urandom_range(0, 1));
            v.addr   = 16'($urandom);
            v.sdata  = 16'($urandom);
            v.srt    = 4'($urandom_range(0, 3));
            v.wbre   = 1'($urandom_range(0, 1));
            v.wbrd   = 4'($urandom_range(0, 3));
            v.wbdata = 16'($urandom);
            v.lat    = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, TO));
            v.rdata  = 16'($urandom);
            model(v, vm);
            apply(vm, 1000 + i);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
